// File: rtl/ledr_driver_pkg.sv
// Shared widths and helpers for the LEDR driver (8 LEDs, 16-step PWM).
package ledr_driver_pkg;

    localparam int LED_W     = 8;
    localparam int PWM_W     = 4;
    localparam int PWM_STEPS = 16;

    typedef logic [LED_W-1:0] led_vec_t;
    typedef logic [PWM_W-1:0] pwm_lvl_t;

    // Duty comparator: LED is driven while the phase is below the level.
    function automatic logic pwm_active(input pwm_lvl_t phase, input pwm_lvl_t level);
        return (phase < level);
    endfunction

endpackage

// File: rtl/ledr_hold_timer.sv
// One LED bit: input register, rise/fall detect and full-brightness hold counter.
// Latency: value and counter update at the sampling edge; no backpressure.
import ledr_driver_pkg::*;

module ledr_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_bit,
    output logic o_value_q,
    output logic o_highlight
);

    localparam int              CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    logic             r_value_q;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_rise;
    logic             w_fall;

    assign w_rise = i_bit & ~r_value_q;
    assign w_fall = ~i_bit & r_value_q;

    // A rise while already counting restarts the full hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value_q  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_value_q <= i_bit;
            if (w_rise) begin
                r_hold_cnt <= HOLD_LOAD;
            end else if (w_fall) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    assign o_value_q   = r_value_q;
    assign o_highlight = (r_hold_cnt != '0);

endmodule

// File: rtl/exponent_accelerator_system_ledr_driver.sv
// Board LED driver: new bits flash at full brightness, steady bits are PWM-dimmed.
// Latency: 2 cycles from led_value to ledr; no backpressure (free-running sink).
import ledr_driver_pkg::*;

module exponent_accelerator_system_ledr_driver #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int PRESCALE    = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] led_value,
    input  logic [PWM_W-1:0] brightness,
    output logic [LED_W-1:0] ledr,
    output logic             busy
);

    localparam int              PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
    localparam pwm_lvl_t        PHASE_LAST = pwm_lvl_t'(PWM_STEPS - 1);

    led_vec_t        w_value_q;
    led_vec_t        w_highlight;
    logic [PS_W-1:0] r_prescale;
    pwm_lvl_t        r_phase;
    pwm_lvl_t        r_bright_q;
    logic            w_tick;
    logic            w_pwm_on;

    for (genvar g = 0; g < LED_W; g++) begin : g_bit
        ledr_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_hold (
            .clk         (clk),
            .reset       (reset),
            .i_bit       (led_value[g]),
            .o_value_q   (w_value_q[g]),
            .o_highlight (w_highlight[g])
        );
    end

    assign w_tick   = (r_prescale == PS_LAST);
    assign w_pwm_on = pwm_active(r_phase, r_bright_q);

    // Brightness is only adopted at the period boundary so a period never mixes two duties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= '0;
            r_phase    <= '0;
            r_bright_q <= '0;
            ledr       <= '0;
            busy       <= 1'b0;
        end else begin
            if (w_tick) begin
                r_prescale <= '0;
                r_phase    <= r_phase + 1'b1;
                if (r_phase == PHASE_LAST) begin
                    r_bright_q <= brightness;
                end
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end
            ledr <= w_value_q & (w_highlight | {LED_W{w_pwm_on}});
            busy <= |w_highlight;
        end
    end

endmodule

// File: tb/tb_exponent_accelerator_system_ledr_driver.sv
// Scoreboard bench for the LEDR driver with HOLD_CYCLES=10, PRESCALE=2.
`timescale 1ns/1ps
module tb_exponent_accelerator_system_ledr_driver;

    localparam int HOLD   = 10;
    localparam int PRE    = 2;
    localparam int PERIOD = 16 * PRE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] led_value = 8'h00;
    logic [3:0] brightness = 4'd0;
    logic [7:0] ledr;
    logic       busy;

    exponent_accelerator_system_ledr_driver #(
        .HOLD_CYCLES (HOLD),
        .PRESCALE    (PRE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_value  (led_value),
        .brightness (brightness),
        .ledr       (ledr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ledr;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference state: edge index, last rise edge per bit, value register, PWM time.
    int         m_edge = 0;
    int         m_rise[8];
    logic [7:0] m_vq = 8'h00;
    int         m_t = 0;
    logic [3:0] m_bq = 4'd0;

    logic [7:0] obs_ledr;
    logic       obs_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock: compare the output of the previous edge, drive, predict this edge.
    task automatic step(input logic rst, input logic [7:0] v, input logic [3:0] b);
        exp_t       e;
        logic [7:0] hl;
        logic       pwm;
        int         age;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            obs_ledr = ledr;
            obs_busy = busy;
            chk("ledr", {24'd0, ledr}, {24'd0, e.ledr});
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
        end
        reset      = rst;
        led_value  = v;
        brightness = b;
        for (int i = 0; i < 8; i++) begin
            age   = m_edge - m_rise[i];
            hl[i] = m_vq[i] && (age >= 1) && (age <= HOLD);
        end
        pwm = (((m_t / PRE) % 16) < int'(m_bq));
        if (rst) begin
            e.ledr = 8'h00;
            e.busy = 1'b0;
            sb.push_back(e);
            m_vq = 8'h00;
            m_t  = 0;
            m_bq = 4'd0;
        end else begin
            e.ledr = m_vq & (hl | {8{pwm}});
            e.busy = |hl;
            sb.push_back(e);
            for (int i = 0; i < 8; i++)
                if (v[i] && !m_vq[i]) m_rise[i] = m_edge;
            if ((m_t % PERIOD) == PERIOD - 1) m_bq = b;
            m_vq = v;
            m_t++;
        end
        m_edge++;
    endtask

    initial begin
        int c_a, c_b, c_c;
        for (int i = 0; i < 8; i++) m_rise[i] = -1000;

        // Reset with all inputs high, then release: rises only show after release.
        repeat (3) step(1'b1, 8'hFF, 4'd0);
        repeat (15) step(1'b0, 8'hFF, 4'd0);
        repeat (5) step(1'b0, 8'h00, 4'd0);

        // Single-bit highlight with PWM off.
        c_a = 0; c_b = 0;
        repeat (20) begin
            step(1'b0, 8'h01, 4'd0);
            c_a += int'(obs_ledr == 8'h01);
            c_b += int'(obs_busy);
        end
        chk("s2_hold_len", c_a, HOLD);
        chk("s2_busy_len", c_b, HOLD);

        // Steady 0xFF at brightness 4.
        repeat (50) step(1'b0, 8'hFF, 4'd4);
        c_a = 0; c_b = 0;
        repeat (2 * PERIOD) begin
            step(1'b0, 8'hFF, 4'd4);
            c_a += int'(obs_ledr == 8'hFF);
            c_b += int'(obs_ledr == 8'h00);
        end
        chk("s3_on_cycles", c_a, 16);
        chk("s3_off_cycles", c_b, 48);

        // Short pulse on bit 0: fall cancels the highlight early.
        repeat (10) step(1'b0, 8'h00, 4'd4);
        c_a = 0;
        repeat (4) begin
            step(1'b0, 8'h01, 4'd4);
            c_a += int'(obs_busy);
        end
        repeat (8) begin
            step(1'b0, 8'h00, 4'd4);
            c_a += int'(obs_busy);
        end
        chk("s4_busy_len", c_a, 4);
        chk("s4_no_residual", {24'd0, obs_ledr}, 32'd0);

        // Brightness change 4 -> 12 mid-period.
        repeat (50) step(1'b0, 8'hFF, 4'd4);
        c_a = 0;
        repeat (PERIOD) begin
            step(1'b0, 8'hFF, 4'd4);
            c_a += int'(obs_ledr == 8'hFF);
        end
        chk("s5_duty_before", c_a, 8);
        repeat (PERIOD / 2) step(1'b0, 8'hFF, 4'd4);
        repeat (40) step(1'b0, 8'hFF, 4'd12);
        c_a = 0;
        repeat (2 * PERIOD) begin
            step(1'b0, 8'hFF, 4'd12);
            c_a += int'(obs_ledr == 8'hFF);
        end
        chk("s5_duty_after", c_a, 48);

        // Bits 0 and 7 rise together; bit 0 drops one cycle and re-rises.
        repeat (40) step(1'b0, 8'h00, 4'd0);
        c_a = 0; c_b = 0; c_c = 0;
        for (int s = 0; s < 25; s++) begin
            step(1'b0, (s == 4) ? 8'h80 : 8'h81, 4'd0);
            c_a += int'(obs_ledr[7]);
            c_b += int'(obs_ledr[0]);
            c_c += int'(obs_busy);
        end
        chk("s6_bit7_len", c_a, 10);
        chk("s6_bit0_len", c_b, 14);
        chk("s6_busy_len", c_c, 15);

        // Reset mid-operation with inputs still set: re-highlight after release.
        repeat (2) step(1'b1, 8'hFF, 4'd8);
        repeat (20) step(1'b0, 8'hFF, 4'd8);

        @(negedge clk);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ledr_last", {24'd0, ledr}, {24'd0, e.ledr});
            chk("busy_last", {31'd0, busy}, {31'd0, e.busy});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
